// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl -- multi-cycle shift sequencer for the integer execution path.
//
// Accepts one shift command (operand, 5-bit shift amount, op) while idle and
// iterates a narrow shift stage of at most STEP bits per cycle until the whole
// amount has been applied. Completion is signalled with a one-cycle done pulse.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      command strobe, accepted only while busy=0
//   op     in   2      00 SLL, 01 SRL, 11 SRA, 10 pass-through
//   a      in   WIDTH  operand
//   shamt  in   5      shift amount 0..31
//   busy   out  1      command in progress
//   done   out  1      one-cycle pulse, res valid
//   res    out  WIDTH  registered result, held until the next completion
//
// Build option:
//   SHIFT_SEQ_SINGLE_CYCLE_EN  when defined, the whole remaining amount is
//                              applied in one step (full barrel shift), so
//                              every command completes one cycle after accept.
module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   w;
    logic [1:0]         opr;
    logic [4:0]         rem;
    logic [4:0]         amt;
    logic [4:0]         rem_step;
    logic [WIDTH-1:0]   w_step;

    // SRA shifts the working value arithmetically; since its MSB is never
    // altered by an arithmetic shift, the sign captured at accept survives
    // every partial step.
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] val,
                                                  input logic [1:0]       sel,
                                                  input logic [4:0]       sh);
        logic signed [WIDTH-1:0] sval;
        sval = val;
        case (sel)
            OP_SLL:  return val << sh;
            OP_SRL:  return val >> sh;
            OP_SRA:  return $unsigned(sval >>> sh);
            default: return val;
        endcase
    endfunction

    // Amount consumed this cycle; pass-through consumes nothing.
    function automatic logic [4:0] step_amt(input logic [4:0] r, input logic [1:0] sel);
        if (sel == OP_PASS) begin
            return 5'd0;
        end
`ifdef SHIFT_SEQ_SINGLE_CYCLE_EN
        return r;
`else
        return (r < STEP_AMT) ? r : STEP_AMT;
`endif
    endfunction

    assign busy = (state == RUN);

    always_comb begin
        state_next = state;
        amt        = step_amt(rem, opr);
        w_step     = shift_by(w, opr, amt);
        // Pass-through clears the remaining count so it finishes in one step.
        rem_step   = (opr == OP_PASS) ? 5'd0 : (rem - amt);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (rem_step == 5'd0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control: remaining count, done pulse and the visible result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= 5'd0;
            done <= 1'b0;
            res  <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                rem <= shamt;
            end else if (state == RUN) begin
                rem <= rem_step;
                if (rem_step == 5'd0) begin
                    res  <= w_step;
                    done <= 1'b1;
                end
            end
        end
    end

    // Datapath: working value and latched op; not reset, since nothing
    // observes them until a command has been accepted.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            w   <= a;
            opr <= op;
        end else if (state == RUN) begin
            w <= w_step;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_res;

    shift_seq_ctrl #(.WIDTH(32), .STEP(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] er;
        int          n;
    } vec_t;

    vec_t vecs[9];

    function automatic int lat(input int n);
`ifdef SHIFT_SEQ_SINGLE_CYCLE_EN
        return 1;
`else
        return n;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Waits for done, counting edges after the accept edge; returns the count
    // or -1 if the cycle budget expired.
    task automatic wait_done(output int n);
        n = 0;
        forever begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (n > 40) begin
                n = -1;
                break;
            end
            chk("busy_while_run", 32'(busy), 32'd1);
            chk("res_held_while_run", res, prev_res);
        end
    endtask

    task automatic do_cmd(input string nm, input logic [1:0] o, input logic [31:0] av,
                          input logic [4:0] sv, input logic [31:0] er, input int en);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; a = av; shamt = sv;
        @(posedge clk); #1;
        start = 1'b0;
        // Inputs are don't-care once accepted.
        a = $urandom; op = 2'($urandom); shamt = 5'($urandom);
        chk({nm, "_busy_after_accept"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({nm, "_latency"}, 32'(n), 32'(lat(en)));
        chk({nm, "_res"}, res, er);
        prev_res = er;
        @(posedge clk); #1;
        chk({nm, "_done_drop"}, 32'(done), 32'd0);
        chk({nm, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int ign_at;
        int rst_at;
        int seen;

        vecs[0] = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 8};
        vecs[1] = '{2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 8};
        vecs[2] = '{2'b11, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 1};
        vecs[3] = '{2'b00, 32'h0000_000F, 5'd0,  32'h0000_000F, 1};
        vecs[4] = '{2'b00, 32'h0000_000F, 5'd4,  32'h0000_00F0, 1};
        vecs[5] = '{2'b00, 32'h0000_000F, 5'd5,  32'h0000_01E0, 2};
        vecs[6] = '{2'b10, 32'h1234_5678, 5'd9,  32'h1234_5678, 1};
        vecs[7] = '{2'b11, 32'hF000_0000, 5'd8,  32'hFFF0_0000, 2};
        vecs[8] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 8};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_res", res, 32'd0);
        prev_res = 32'd0;

        for (int i = 0; i < 9; i++) begin
            do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].sh, vecs[i].er, vecs[i].n);
        end

        // Start while busy is ignored.
        ign_at = lat(8) > 3 ? 3 : 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'h1; shamt = 5'd31;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        forever begin
            if (n == ign_at) begin
                start = 1'b1; a = 32'hFFFF_FFFF; shamt = 5'd1; op = 2'b00;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (done || n > 40) break;
        end
        start = 1'b0;
        chk("busy_ign_latency", 32'(n), 32'(lat(8)));
        chk("busy_ign_res", res, 32'h8000_0000);
        @(posedge clk); #1;
        chk("busy_ign_not_queued", 32'(busy), 32'd0);
        chk("busy_ign_done_drop", 32'(done), 32'd0);
        prev_res = 32'h8000_0000;

        // Back-to-back: new command held on the done cycle.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'h3; shamt = 5'd6;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        chk("b2b_first_latency", 32'(n), 32'(lat(2)));
        chk("b2b_first_res", res, 32'h0000_00C0);
        start = 1'b1; op = 2'b01; a = 32'hF0; shamt = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_gap_done", 32'(done), 32'd0);
        chk("b2b_gap_busy", 32'(busy), 32'd1);
        chk("b2b_gap_res_held", res, 32'h0000_00C0);
        @(posedge clk); #1;
        chk("b2b_second_done", 32'(done), 32'd1);
        chk("b2b_second_res", res, 32'h0000_000F);
        @(posedge clk); #1;
        chk("b2b_second_drop", 32'(done), 32'd0);
        prev_res = 32'h0000_000F;

        // Reset mid-run aborts the command.
        rst_at = lat(5) > 2 ? 2 : 0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; shamt = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < rst_at; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_res", res, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("rst_mid_no_done", 32'(seen), 32'd0);
        prev_res = 32'd0;
        do_cmd("after_rst", 2'b01, 32'hF0, 5'd4, 32'h0000_000F, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
